// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the PC / fetch front end.
// FSM encoding, NOP word, default PC step.
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_PARK = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP = 32'h0000_0000;

  localparam int unsigned PC_INC_DEF = 4;

endpackage

// File: rtl/fetch_park_buf.sv
// Single-entry holding register for one fetched word and its PC.
// Catches a response that arrives while decode is stalled.
module fetch_park_buf
  import pc_fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        drain,
  input  logic        flush,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        vld,
  output logic [31:0] instr,
  output logic [31:0] pc
);

  // Flush beats load, load beats drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld   <= 1'b0;
      instr <= NOP;
      pc    <= 32'h0;
    end else if (flush) begin
      vld   <= 1'b0;
      instr <= NOP;
    end else if (load) begin
      vld   <= 1'b1;
      instr <= in_instr;
      pc    <= in_pc;
    end else if (drain) begin
      vld   <= 1'b0;
      instr <= NOP;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter, imem request port and IF/ID register.
// Handles redirects, stale-response kill and decode stall.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_INC   = PC_INC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pcsel,
  input  logic [31:0] target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out
);

  localparam logic [31:0] INC = 32'(PC_INC);

  fetch_state_e state;
  logic [31:0]  pc;
  logic         kill;

  logic [31:0] pc_nxt;
  logic        park_load;
  logic        park_drain;
  logic        park_vld;
  logic [31:0] park_instr;
  logic [31:0] park_pc;

  assign pc_nxt = pc + INC;

  assign park_load = (state == S_REQ) && imem_ack
                   && !pcsel && !kill
                   && stall && instr_valid;

  assign park_drain = (state == S_PARK)
                    && !pcsel && !stall;

  fetch_park_buf u_park (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (park_load),
    .drain    (park_drain),
    .flush    (pcsel),
    .in_instr (imem_rdata),
    .in_pc    (imem_addr),
    .vld      (park_vld),
    .instr    (park_instr),
    .pc       (park_pc)
  );

  // Fetch FSM with registered request and IF/ID outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      kill        <= 1'b0;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr_valid <= 1'b0;
      instr_out   <= NOP;
      pc_out      <= 32'h0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (pcsel) begin
            pc          <= target;
            imem_addr   <= target;
            imem_req    <= 1'b1;
            state       <= S_REQ;
            instr_valid <= 1'b0;
            instr_out   <= NOP;
          end else if (!stall) begin
            imem_addr   <= pc;
            imem_req    <= 1'b1;
            state       <= S_REQ;
            instr_valid <= 1'b0;
            instr_out   <= NOP;
          end
        end
        S_REQ: begin
          if (pcsel) begin
            pc          <= target;
            instr_valid <= 1'b0;
            instr_out   <= NOP;
            if (imem_ack) begin
              kill      <= 1'b0;
              imem_addr <= target;
            end else begin
              kill      <= 1'b1;
            end
          end else if (imem_ack && kill) begin
            // pc already holds the redirect target
            kill      <= 1'b0;
            imem_addr <= pc;
            if (!stall) begin
              instr_valid <= 1'b0;
              instr_out   <= NOP;
            end
          end else if (park_load) begin
            pc       <= pc_nxt;
            imem_req <= 1'b0;
            state    <= S_PARK;
          end else if (imem_ack) begin
            instr_valid <= 1'b1;
            instr_out   <= imem_rdata;
            pc_out      <= imem_addr;
            pc          <= pc_nxt;
            imem_addr   <= pc_nxt;
          end else if (!stall) begin
            instr_valid <= 1'b0;
            instr_out   <= NOP;
          end
        end
        S_PARK: begin
          if (pcsel) begin
            pc          <= target;
            imem_addr   <= target;
            imem_req    <= 1'b1;
            state       <= S_REQ;
            instr_valid <= 1'b0;
            instr_out   <= NOP;
          end else if (!stall) begin
            instr_valid <= park_vld;
            instr_out   <= park_instr;
            pc_out      <= park_pc;
            imem_addr   <= pc;
            imem_req    <= 1'b1;
            state       <= S_REQ;
          end
        end
        default: begin
          state    <= S_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit.
// Memory returns addr ^ 0x1357_9BDF as the instruction word.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        pcsel;
  logic [31:0] target;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] pc_out;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata = word(imem_addr);

  pc_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .PC_INC   (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pcsel       (pcsel),
    .target      (target),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_out   (instr_out),
    .pc_out      (pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves DUT in REQ with request at 0x0 outstanding.
  task automatic do_reset();
    rst_n = 1'b0;
    pcsel = 1'b0;
    target = 32'h0;
    stall = 1'b0;
    imem_ack = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pcsel = 1'b0;
    target = 32'h0;
    stall = 1'b0;
    imem_ack = 1'b0;
    tick();
    tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h want 0", imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", instr_valid); end
    checks++; if (instr_out !== 32'h0) begin errors++; $display("FAIL rst_instr got %h want 0", instr_out); end
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL rst_pc_out got %h want 0", pc_out); end
    rst_n = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rst_first_req got %b want 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_first_addr got %h want 0", imem_addr); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc;
    do_reset();
    imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_pc = 32'(i * 4);
      tick();
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got %b want 1", i, instr_valid); end
      checks++; if (pc_out !== exp_pc) begin errors++; $display("FAIL b2b_pc_out[%0d] got %h want %h", i, pc_out, exp_pc); end
      checks++; if (instr_out !== word(exp_pc)) begin errors++; $display("FAIL b2b_instr[%0d] got %h want %h", i, instr_out, word(exp_pc)); end
      checks++; if (imem_addr !== exp_pc + 32'h4 || imem_req !== 1'b1) begin errors++; $display("FAIL b2b_next_req[%0d] got %b/%h want 1/%h", i, imem_req, imem_addr, exp_pc + 32'h4); end
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_redirect();
    do_reset();
    imem_ack = 1'b1;
    tick();
    tick();
    imem_ack = 1'b0;
    tick();
    tick();
    checks++; if (imem_addr !== 32'h8 || imem_req !== 1'b1) begin errors++; $display("FAIL redir_wait got %b/%h want 1/00000008", imem_req, imem_addr); end
    pcsel = 1'b1;
    target = 32'h100;
    tick();
    pcsel = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_inval got %b want 0", instr_valid); end
    checks++; if (imem_addr !== 32'h8 || imem_req !== 1'b1) begin errors++; $display("FAIL redir_hold got %b/%h want 1/00000008", imem_req, imem_addr); end
    imem_ack = 1'b1;
    tick();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_drop got %b want 0", instr_valid); end
    checks++; if (imem_addr !== 32'h100 || imem_req !== 1'b1) begin errors++; $display("FAIL redir_new_req got %b/%h want 1/00000100", imem_req, imem_addr); end
    tick();
    imem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b1 || pc_out !== 32'h100) begin errors++; $display("FAIL redir_load got %b/%h want 1/00000100", instr_valid, pc_out); end
    checks++; if (instr_out !== word(32'h100)) begin errors++; $display("FAIL redir_instr got %h want %h", instr_out, word(32'h100)); end
    checks++; if (imem_addr !== 32'h104) begin errors++; $display("FAIL redir_seq got %h want 00000104", imem_addr); end
  endtask

  task automatic test_stall_park();
    do_reset();
    imem_ack = 1'b1;
    tick();
    tick();
    stall = 1'b1;
    tick();
    imem_ack = 1'b0;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL park_req got %b want 0", imem_req); end
    checks++; if (instr_valid !== 1'b1 || pc_out !== 32'h4) begin errors++; $display("FAIL park_hold got %b/%h want 1/00000004", instr_valid, pc_out); end
    tick();
    checks++; if (imem_req !== 1'b0 || pc_out !== 32'h4) begin errors++; $display("FAIL park_hold2 got %b/%h want 0/00000004", imem_req, pc_out); end
    stall = 1'b0;
    tick();
    checks++; if (instr_valid !== 1'b1 || pc_out !== 32'h8) begin errors++; $display("FAIL park_drain got %b/%h want 1/00000008", instr_valid, pc_out); end
    checks++; if (instr_out !== word(32'h8)) begin errors++; $display("FAIL park_instr got %h want %h", instr_out, word(32'h8)); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin errors++; $display("FAIL park_next got %b/%h want 1/0000000c", imem_req, imem_addr); end
  endtask

  task automatic test_park_redirect();
    do_reset();
    imem_ack = 1'b1;
    tick();
    tick();
    stall = 1'b1;
    tick();
    imem_ack = 1'b0;
    pcsel = 1'b1;
    target = 32'h40;
    tick();
    pcsel = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL pkredir_inval got %b want 0", instr_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("FAIL pkredir_req got %b/%h want 1/00000040", imem_req, imem_addr); end
    stall = 1'b0;
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b1 || pc_out !== 32'h40) begin errors++; $display("FAIL pkredir_load got %b/%h want 1/00000040", instr_valid, pc_out); end
    tick();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL pkredir_no_park got %b want 0", instr_valid); end
  endtask

  task automatic test_wrap();
    do_reset();
    pcsel = 1'b1;
    target = 32'hFFFF_FFFC;
    tick();
    pcsel = 1'b0;
    imem_ack = 1'b1;
    tick();
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req got %h want fffffffc", imem_addr); end
    tick();
    imem_ack = 1'b0;
    checks++; if (pc_out !== 32'hFFFF_FFFC || instr_valid !== 1'b1) begin errors++; $display("FAIL wrap_load got %b/%h want 1/fffffffc", instr_valid, pc_out); end
    checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin errors++; $display("FAIL wrap_next got %b/%h want 1/00000000", imem_req, imem_addr); end
  endtask

  task automatic test_async_reset();
    do_reset();
    imem_ack = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL arst_req got %b want 0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b want 0", instr_valid); end
    imem_ack = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL arst_restart got %b/%h want 1/00000000", imem_req, imem_addr); end
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b1 || pc_out !== 32'h0) begin errors++; $display("FAIL arst_load got %b/%h want 1/00000000", instr_valid, pc_out); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_redirect();
    test_stall_park();
    test_park_redirect();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

- Owns the program counter and the instruction-fetch front end.
- Consumes the branch decision (`pcsel`) and branch target produced by branch resolution in execute.
- Drives a request/acknowledge instruction-memory port and fills the IF/ID register consumed by decode.
- Handles redirects, in-flight fetch cancellation, and decode back-pressure (stall) without losing or duplicating instructions.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, address of the first fetch after reset.
- `PC_INC`, 4, PC increment per sequential instruction (byte addressing).

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `pcsel`  in  1  one-cycle redirect pulse from branch resolution.
- `target`  in  32  redirect address; valid when `pcsel`=1.
- `stall`  in  1  decode cannot accept; IF/ID must hold.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; stable while `imem_req`=1 and no ack.
- `imem_ack`  in  1  one-cycle response strobe; completes the outstanding request.
- `imem_rdata`  in  32  instruction word; valid with `imem_ack`.
- `instr_valid`  out  1  IF/ID holds a live instruction.
- `instr_out`  out  32  IF/ID instruction; NOP (32'h0) when invalid.
- `pc_out`  out  32  address of `instr_out`.

## Operation
Internal state:
- `pc`: next address to request.
- `kill`: outstanding response is stale.
- Park buffer: one instruction plus its PC.
- FSM: IDLE, REQ, PARK.

IDLE (`imem_req`=0):
- Entered from reset.
- Go to REQ when `stall`=0 or `pcsel`=1; `imem_addr` is latched from `pc` on entry.

REQ (`imem_req`=1):
- `imem_addr` is held until `imem_ack`.
- On ack with `kill`=1 or `pcsel`=1: drop `imem_rdata`, clear `kill`, re-request at `pc` the next cycle (stay in REQ).
- On ack with `stall`=1 and `instr_valid`=1: write the word and its address into the park buffer, `pc` += `PC_INC`, go to PARK.
- On any other ack: load IF/ID, `pc` += `PC_INC`, issue the next request at the new `pc` the following cycle (back-to-back, no bubble).

PARK (`imem_req`=0):
- When `stall`=0: move the park buffer into IF/ID, go to REQ.

Redirect (`pcsel`=1), any state, highest priority:
- `pc` <= `target`.
- `instr_valid` <= 0.
- Park buffer discarded.
- If in REQ without ack the same cycle: set `kill` and keep the request up until acked.
- From PARK or IDLE: go to REQ with `imem_addr` = `target`.

IF/ID update when `stall`=0 and no redirect:
- Load it if a word is delivered this cycle (ack or park drain).
- Otherwise clear `instr_valid`.

IF/ID update when `stall`=1: hold.

Arithmetic: `pc` + `PC_INC` is 32-bit modulo; 32'hFFFF_FFFC wraps to 0. No alignment check is done on `target`.

## Timing
Reset values (async, `rst_n`=0):
- State IDLE, `pc` = `RESET_PC`, `kill` = 0.
- `imem_req` = 0, `imem_addr` = `RESET_PC`.
- `instr_valid` = 0, `instr_out` = 0, `pc_out` = 0.

After reset:
- First `imem_req` rises one cycle after `rst_n` deasserts, provided `stall`=0.

Latency and throughput:
- Ack in cycle N → `instr_valid`=1 in cycle N+1.
- Sustained throughput is one instruction per cycle with zero-wait memory.

Redirect in cycle N:
- IF/ID is invalid in N+1.
- Request at `target` is visible in N+1 if no fetch is outstanding.
- Otherwise the request at `target` is issued the cycle after the stale ack.

Simultaneous events:
- `pcsel` and `stall`: `pcsel` wins.
- `pcsel` and ack: the word is dropped.
- Repeated `pcsel` before the stale ack: the last `target` wins; a single `kill` covers it.

`rst_n` asserted mid-request: `imem_req` drops immediately. The memory side must abandon the request.

## Structure
Shared package:
- FSM state enum.
- `NOP` constant (32'h0).
- `PC_INC` default.

Sub-module: `fetch_park_buf` (single-entry instruction+PC holding register with load/drain/flush).

## Test plan
- **Reset then run, zero-wait ack:** requests at 0x0, 0x4, 0x8 back-to-back; `pc_out` 0x0, 0x4, 0x8 on consecutive cycles from the cycle after the first ack.
- **Redirect while outstanding:**
  - Stimulus: `pcsel`=1, `target`=0x100 while the request at 0x8 has waited 2 cycles without ack.
  - Required: 0x8 data is dropped; the next request is 0x100; no IF/ID load from 0x8.
- **Stall on ack:**
  - Stimulus: `stall`=1 with IF/ID holding 0x4 when the 0x8 ack arrives.
  - Required: 0x8 is parked and `imem_req`=0 during the stall. After release, IF/ID=0x8 and the next request is 0xC.
- **Stall plus redirect in PARK:**
  - Stimulus: `pcsel`=1, `target`=0x40 while parked.
  - Required: park is dropped, `instr_valid`=0, next request 0x40.
- **Wrap:** redirect to 0xFFFF_FFFC; the request after it is 0x0.
- **Async reset mid-fetch:** `rst_n` low between edges → `imem_req`=0 and `instr_valid`=0 immediately; after release, the fetch restarts at `RESET_PC`.
